// File: rtl/arbmux.sv
// Shared types for the instruction/data cache memory arbiter.
package arbmux;

    // Which cache currently owns the physical-memory line port.
    typedef enum bit {icache = 1'b0, dcache = 1'b1} arb_grant_t;

    // Arbiter sequencing: pick, wait on memory, then one quiet cycle.
    typedef enum bit [1:0] {IDLE, SERVE_I, SERVE_D, RECOVER} arb_state_t;

    // Starvation counter width; covers STARVE_LIMIT up to 15.
    localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant decision: dcache wins ties until the icache has
// waited through STARVE_LIMIT consecutive dcache grants.
module arb_grant_sel
    import arbmux::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 i_read,
    input  logic                 d_req,
    input  logic [CNT_WIDTH-1:0] starve_cnt,
    output logic                 grant_valid,
    output arb_grant_t           grant,
    output logic                 starve_inc
);

    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    // Pick a winner; starve_inc marks a dcache grant taken over a waiting icache.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        grant_valid = i_read | d_req;
        grant       = icache;
        starve_inc  = 1'b0;
        if (d_req && i_read) begin
            if (starve_cnt < LIMIT) begin
                grant      = dcache;
                starve_inc = 1'b1;
            end
        end else if (d_req) begin
            grant = dcache;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one cacheline memory port between the icache and the dcache.
// The winner's address/data are latched at grant; the memory response is
// routed back only to that cache, followed by one RECOVER cycle so a
// request still high during the resp pulse is not granted again.
module cache_mem_arbiter
    import arbmux::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_WIDTH   = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0]  starve_cnt_q, starve_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
    // pmem_write_q doubles as the latched direction bit of a dcache grant.
    logic                  pmem_read_q, pmem_read_d;
    logic                  pmem_write_q, pmem_write_d;
    logic                  i_resp_q, i_resp_d;
    logic                  d_resp_q, d_resp_d;

    logic                  d_req;
    logic                  grant_valid;
    logic                  starve_inc;
    arb_grant_t            grant;

    assign d_req = d_read | d_write;

    arb_grant_sel #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant_sel (
        .i_read      (i_read),
        .d_req       (d_req),
        .starve_cnt  (starve_cnt_q),
        .grant_valid (grant_valid),
        .grant       (grant),
        .starve_inc  (starve_inc)
    );

    // Next-state, grant latching and response routing.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant == dcache) begin
                        state_d      = SERVE_D;
                        addr_d       = d_address;
                        wdata_d      = d_wdata;
                        // Both strobes high is illegal; it resolves to a write.
                        pmem_write_d = d_write;
                        pmem_read_d  = ~d_write;
                        starve_cnt_d = starve_inc ? starve_cnt_q + CNT_WIDTH'(1) : '0;
                    end else begin
                        state_d      = SERVE_I;
                        addr_d       = i_address;
                        pmem_read_d  = 1'b1;
                        pmem_write_d = 1'b0;
                        starve_cnt_d = '0;
                    end
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_d     = RECOVER;
                    pmem_read_d = 1'b0;
                    i_resp_d    = 1'b1;
                    i_rdata_d   = pmem_rdata;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_d      = RECOVER;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    d_resp_d     = 1'b1;
                    if (pmem_read_q) begin
                        d_rdata_d = pmem_rdata;
                    end
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction silently.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the line-wide data registers are reset too, since the
        // returned rdata must read as zero after reset.
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_rdata      = i_rdata_q;
    assign i_resp       = i_resp_q;
    assign d_rdata      = d_rdata_q;
    assign d_resp       = d_resp_q;

    // Illegal dcache request encoding, and memory responses nobody asked for.
    a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst)
        !(d_read && d_write));
    a_resp_only_in_serve: assert property (@(posedge clk) disable iff (!rst)
        !(pmem_resp && (state_q == IDLE || state_q == RECOVER)));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: table of single-requester
// transactions plus hand-written arbitration, reset and stale-request cases.
module tb_cache_mem_arbiter;
    import arbmux::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_read = 1'b0;
    logic [31:0]  i_address = '0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_address = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    cache_mem_arbiter #(
        .ADDR_WIDTH(32), .LINE_WIDTH(256), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        arb_grant_t   cache;
        logic [255:0] data;
    } exp_t;

    typedef struct {
        string        name;
        logic         i_rd, d_rd, d_wr;
        logic [31:0]  ia, da;
        logic [255:0] wd, mem;
        int           lat;
        arb_grant_t   exp_cache;
        logic         exp_read;
        logic [31:0]  exp_addr;
    } vec_t;

    localparam logic [255:0] JUNK = {8{32'hDEADBEEF}};

    exp_t         sb_q[$];
    vec_t         vecs[5];
    int           n_checks = 0;
    int           n_pass = 0;
    logic [255:0] i_rdata_m = '0;
    logic [255:0] d_rdata_m = '0;
    logic         i_resp_prev = 1'b0;
    logic         d_resp_prev = 1'b0;

    task automatic tally(input string name, input bit ok, input string act, input string exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tally(name, act === exp, $sformatf("%b", act), $sformatf("%b", exp));
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tally(name, act === exp, $sformatf("%h", act), $sformatf("%h", exp));
    endtask

    task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
        tally(name, act === exp, $sformatf("%h", act), $sformatf("%h", exp));
    endtask

    // Scoreboard pop on each resp pulse; rdata of a cache without a pulse must hold.
    task automatic monitor();
        exp_t e;
        check1("i_resp_one_cycle", i_resp & i_resp_prev, 1'b0);
        check1("d_resp_one_cycle", d_resp & d_resp_prev, 1'b0);
        if (i_resp) begin
            check1("i_resp_expected", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check1("i_resp_owner", e.cache == icache, 1'b1);
                check256("i_rdata", i_rdata, e.data);
                i_rdata_m = e.data;
            end
        end else begin
            check256("i_rdata_hold", i_rdata, i_rdata_m);
        end
        if (d_resp) begin
            check1("d_resp_expected", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check1("d_resp_owner", e.cache == dcache, 1'b1);
                check256("d_rdata", d_rdata, e.data);
                d_rdata_m = e.data;
            end
        end else begin
            check256("d_rdata_hold", d_rdata, d_rdata_m);
        end
        i_resp_prev = i_resp;
        d_resp_prev = d_resp;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(pmem_read || pmem_write) && n < 20);
        check1({name, "_strobe"}, pmem_read | pmem_write, 1'b1);
    endtask

    // Strobe is already up: hold it for lat cycles, answer, and expect one resp.
    task automatic serve(input string name, input int lat, input logic [255:0] data,
                         input arb_grant_t cache, input logic is_read,
                         input logic [31:0] addr, input logic [255:0] wdata);
        exp_t e;
        for (int k = 0; k < lat; k++) begin
            check1({name, "_rd"}, pmem_read, is_read);
            check1({name, "_wr"}, pmem_write, ~is_read);
            check32({name, "_addr"}, pmem_address, addr);
            if (!is_read) check256({name, "_wdata"}, pmem_wdata, wdata);
            if (k == lat - 1) begin
                pmem_rdata = data;
                pmem_resp  = 1'b1;
                e.cache = cache;
                e.data  = is_read ? data : ((cache == icache) ? i_rdata_m : d_rdata_m);
                sb_q.push_back(e);
            end
            step();
        end
        pmem_resp  = 1'b0;
        pmem_rdata = JUNK;
        check1({name, "_resp_seen"}, sb_q.size() == 0, 1'b1);
        check1({name, "_rd_drop"}, pmem_read, 1'b0);
        check1({name, "_wr_drop"}, pmem_write, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] w1;
        logic [255:0] w2;
        logic [31:0]  exp_addr;
        arb_grant_t   exp_cache;
        w1 = {8{32'h12345678}};
        w2 = {8{32'hCAFEF00D}};

        vecs[0] = '{"lone_i",   1, 0, 0, 32'h0000_0060, 32'h0,          '0, {32{8'hA5}},         5, icache, 1, 32'h0000_0060};
        vecs[1] = '{"d_read",   0, 1, 0, 32'h0,          32'h8000_0040, '0, {8{32'h0F0F_1E1E}},  2, dcache, 1, 32'h8000_0040};
        vecs[2] = '{"d_write",  0, 0, 1, 32'h0,          32'h8000_0080, w2, JUNK,                3, dcache, 0, 32'h8000_0080};
        vecs[3] = '{"i_fast",   1, 0, 0, 32'hFFFF_FFE0, 32'h0,          '0, {8{32'h5A5A_0001}},  1, icache, 1, 32'hFFFF_FFE0};
        vecs[4] = '{"d_fast",   0, 1, 0, 32'h0,          32'h0000_0020, '0, {8{32'h7777_8888}},  1, dcache, 1, 32'h0000_0020};

        // Reset state.
        #2;
        check1("rst_pmem_read", pmem_read, 1'b0);
        check1("rst_pmem_write", pmem_write, 1'b0);
        check32("rst_pmem_address", pmem_address, 32'h0);
        check256("rst_pmem_wdata", pmem_wdata, '0);
        check1("rst_i_resp", i_resp, 1'b0);
        check1("rst_d_resp", d_resp, 1'b0);
        check256("rst_i_rdata", i_rdata, '0);
        check256("rst_d_rdata", d_rdata, '0);
        check32("rst_starve", 32'(dut.starve_cnt_q), 32'h0);
        step();
        rst = 1'b1;
        step();

        // Table of single-requester transactions.
        for (int v = 0; v < 5; v++) begin
            i_read = vecs[v].i_rd; i_address = vecs[v].ia;
            d_read = vecs[v].d_rd; d_write = vecs[v].d_wr;
            d_address = vecs[v].da; d_wdata = vecs[v].wd;
            step();
            check1({vecs[v].name, "_lat1"}, pmem_read | pmem_write, 1'b1);
            serve(vecs[v].name, vecs[v].lat, vecs[v].mem, vecs[v].exp_cache,
                  vecs[v].exp_read, vecs[v].exp_addr, vecs[v].wd);
            i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
            step();
        end

        // Write-back with the request changed mid-flight.
        d_write = 1'b1; d_address = 32'h8000_0020; d_wdata = w1;
        step();
        check1("wb_lat1", pmem_write, 1'b1);
        d_address = 32'hDEAD_0000; d_wdata = ~w1;
        serve("wb_change", 4, JUNK, dcache, 1'b0, 32'h8000_0020, w1);
        d_write = 1'b0;
        step();

        // Simultaneous requests: D first, then I after RECOVER.
        i_read = 1'b1; i_address = 32'h0000_0100;
        d_read = 1'b1; d_address = 32'h8000_0100;
        step();
        check32("sim_first_d", pmem_address, 32'h8000_0100);
        serve("sim_d", 3, {8{32'h1111_2222}}, dcache, 1'b1, 32'h8000_0100, '0);
        d_read = 1'b0;
        step();
        check1("sim_recover_quiet", pmem_read, 1'b0);
        step();
        check1("sim_i_granted", pmem_read, 1'b1);
        serve("sim_i", 2, {8{32'h3333_4444}}, icache, 1'b1, 32'h0000_0100, '0);
        i_read = 1'b0;
        step();

        // Stale request held through the resp cycle.
        d_read = 1'b1; d_address = 32'h8000_0200;
        step();
        serve("stale", 2, {8{32'h9999_AAAA}}, dcache, 1'b1, 32'h8000_0200, '0);
        step();
        d_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check1("stale_no_reissue", pmem_read | pmem_write, 1'b0);
        end

        // Reset during SERVE_D.
        d_write = 1'b1; d_address = 32'h8000_0300; d_wdata = w2;
        step();
        check1("rmid_granted", pmem_write, 1'b1);
        step();
        #2;
        rst = 1'b0;
        #1;
        check1("rmid_pmem_write", pmem_write, 1'b0);
        check1("rmid_pmem_read", pmem_read, 1'b0);
        check32("rmid_pmem_address", pmem_address, 32'h0);
        check1("rmid_d_resp", d_resp, 1'b0);
        i_rdata_m = '0; d_rdata_m = '0;
        d_write = 1'b0; d_wdata = '0;
        step();
        step();
        rst = 1'b1;
        step();
        i_read = 1'b1; i_address = 32'h0000_0200;
        step();
        check32("rmid_i_addr", pmem_address, 32'h0000_0200);
        serve("rmid_i", 2, {8{32'hBBBB_CCCC}}, icache, 1'b1, 32'h0000_0200, '0);
        i_read = 1'b0;
        step();

        // Starvation guard: four D grants, then I.
        i_read = 1'b1; i_address = 32'h0000_0400;
        d_read = 1'b1; d_address = 32'h8000_0400;
        for (int g = 0; g < 5; g++) begin
            wait_strobe($sformatf("starve%0d", g));
            exp_cache = (g == 4) ? icache : dcache;
            exp_addr  = (g == 4) ? 32'h0000_0400 : 32'h8000_0400;
            check32($sformatf("starve_grant%0d", g), pmem_address, exp_addr);
            serve($sformatf("starve%0d", g), 2, {8{32'h0000_1000 + 32'(g)}},
                  exp_cache, 1'b1, exp_addr, '0);
            if (g == 4) begin
                i_read = 1'b0; d_read = 1'b0;
            end
            step();
        end
        check32("starve_cleared", 32'(dut.starve_cnt_q), 32'h0);
        step();
        check1("starve_idle", pmem_read | pmem_write, 1'b0);

        check32("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
